// File: rtl/gate_bus_serializer.sv
// Parallel-to-serial transmitter for the bit-serial gate path. Words are accepted over a
// valid/ready handshake and shifted out one bit per serial transfer, with a last-bit marker.
module gate_bus_serializer #(
    parameter int         NrOfBits    = 8,
    parameter logic [1:0] BubblesMask = 2'b00,
    parameter bit         LsbFirst    = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic [NrOfBits-1:0] dataIn,
    input  logic                dataValid,
    output logic                dataReady,
    output logic                serialOut,
    output logic                serialValid,
    input  logic                serialReady,
    output logic                serialLast,
    output logic                busy
);

    localparam int CntW = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    logic [NrOfBits-1:0] shreg;
    logic [CntW-1:0]     cnt;
    logic                accept;
    logic                xfer;
    logic                head;

    // Moves the register one place toward whichever end is transmitted first, zero-filling.
    function automatic logic [NrOfBits-1:0] shift_toward_head(input logic [NrOfBits-1:0] v);
        if (LsbFirst) begin
            return v >> 1;
        end
        return v << 1;
    endfunction

    // A new word may enter while the final bit of the current one is being taken.
    assign dataReady = (state == IDLE) ||
                       ((state == SHIFT) && (cnt == '0) && serialReady && tick);
    assign accept    = dataValid && dataReady;
    assign xfer      = tick && serialValid && serialReady;
    assign head      = LsbFirst ? shreg[0] : shreg[NrOfBits-1];
    assign serialOut = serialValid & (head ^ BubblesMask[1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            serialValid <= 1'b0;
            serialLast  <= 1'b0;
            busy        <= 1'b0;
        end else if (tick) begin
            if (accept) begin
                shreg       <= BubblesMask[0] ? ~dataIn : dataIn;
                cnt         <= CntW'(NrOfBits - 1);
                state       <= SHIFT;
                serialValid <= 1'b1;
                serialLast  <= (NrOfBits == 1);
                busy        <= 1'b1;
            end else if (xfer) begin
                if (cnt != '0) begin
                    shreg      <= shift_toward_head(shreg);
                    cnt        <= cnt - 1'b1;
                    serialLast <= (cnt == CntW'(1));
                end else begin
                    state       <= IDLE;
                    shreg       <= '0;
                    serialValid <= 1'b0;
                    serialLast  <= 1'b0;
                    busy        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_bus_serializer.sv
// Directed bench for gate_bus_serializer: three configurations (8-bit LSB-first plain,
// 8-bit MSB-first with both bubbles, 1-bit) driven from one linear stimulus sequence.
module tb_gate_bus_serializer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tick  = 1'b1;

    always #5 clock = ~clock;

    // Configuration A: NrOfBits=8, no bubbles, LSB first
    logic [7:0] dataIn_a = '0;
    logic dataValid_a = 1'b0, dataReady_a, serialOut_a, serialValid_a;
    logic serialReady_a = 1'b1, serialLast_a, busy_a;

    // Configuration B: NrOfBits=8, both bubbles, MSB first
    logic [7:0] dataIn_b = '0;
    logic dataValid_b = 1'b0, dataReady_b, serialOut_b, serialValid_b;
    logic serialReady_b = 1'b1, serialLast_b, busy_b;

    // Configuration C: NrOfBits=1
    logic [0:0] dataIn_c = '0;
    logic dataValid_c = 1'b0, dataReady_c, serialOut_c, serialValid_c;
    logic serialReady_c = 1'b1, serialLast_c, busy_c;

    gate_bus_serializer #(.NrOfBits(8), .BubblesMask(2'b00), .LsbFirst(1'b1)) dut_a (
        .clock(clock), .reset(reset), .tick(tick),
        .dataIn(dataIn_a), .dataValid(dataValid_a), .dataReady(dataReady_a),
        .serialOut(serialOut_a), .serialValid(serialValid_a), .serialReady(serialReady_a),
        .serialLast(serialLast_a), .busy(busy_a)
    );

    gate_bus_serializer #(.NrOfBits(8), .BubblesMask(2'b11), .LsbFirst(1'b0)) dut_b (
        .clock(clock), .reset(reset), .tick(tick),
        .dataIn(dataIn_b), .dataValid(dataValid_b), .dataReady(dataReady_b),
        .serialOut(serialOut_b), .serialValid(serialValid_b), .serialReady(serialReady_b),
        .serialLast(serialLast_b), .busy(busy_b)
    );

    gate_bus_serializer #(.NrOfBits(1), .BubblesMask(2'b00), .LsbFirst(1'b1)) dut_c (
        .clock(clock), .reset(reset), .tick(tick),
        .dataIn(dataIn_c), .dataValid(dataValid_c), .dataReady(dataReady_c),
        .serialOut(serialOut_c), .serialValid(serialValid_c), .serialReady(serialReady_c),
        .serialLast(serialLast_c), .busy(busy_c)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tickclk();
        @(posedge clock);
        #1;
    endtask

    // Sends one word on configuration A with no backpressure and checks all eight bits.
    task automatic send_a(input logic [7:0] w, input string tag);
        dataIn_a      = w;
        dataValid_a   = 1'b1;
        serialReady_a = 1'b1;
        tickclk();
        dataValid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_valid"}, serialValid_a, 1'b1);
            chk({tag, "_busy"}, busy_a, 1'b1);
            chk({tag, "_out"}, serialOut_a, w[i]);
            chk({tag, "_last"}, serialLast_a, (i == 7));
            tickclk();
        end
        chk({tag, "_idle_valid"}, serialValid_a, 1'b0);
        chk({tag, "_idle_busy"}, busy_a, 1'b0);
        chk({tag, "_idle_ready"}, dataReady_a, 1'b1);
    endtask

    logic [7:0] w4;
    logic [7:0] rx4;
    logic [7:0] exp2;
    logic [15:0] exp3;
    logic prev_out, prev_last, prev_xfer, xfer_now;
    int n;

    initial begin
        // Reset state
        #2;
        chk("rst_valid", serialValid_a, 1'b0);
        chk("rst_out", serialOut_a, 1'b0);
        chk("rst_last", serialLast_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_ready", dataReady_a, 1'b1);
        chk("rst_b_out", serialOut_b, 1'b0);
        #1;
        reset = 1'b1;

        // Test 1: 8'hA5 LSB first
        send_a(8'hA5, "t1");

        // Test 2: MSB first with both bubbles; 0F -> F0 -> 1,1,1,1,0,0,0,0 -> inverted
        exp2 = 8'hF0;
        dataIn_b    = 8'h0F;
        dataValid_b = 1'b1;
        tickclk();
        dataValid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", serialValid_b, 1'b1);
            chk("t2_out", serialOut_b, exp2[i]);
            chk("t2_last", serialLast_b, (i == 7));
            tickclk();
        end
        chk("t2_idle_valid", serialValid_b, 1'b0);
        chk("t2_idle_out", serialOut_b, 1'b0);

        // Test 3: back-to-back 01 then 80
        exp3 = 16'h8001;
        dataIn_a    = 8'h01;
        dataValid_a = 1'b1;
        tickclk();
        dataIn_a = 8'h80;
        for (int i = 0; i < 16; i++) begin
            chk("t3_valid", serialValid_a, 1'b1);
            chk("t3_out", serialOut_a, exp3[i]);
            chk("t3_last", serialLast_a, (i == 7) || (i == 15));
            chk("t3_ready", dataReady_a, (i == 7) || (i == 15));
            tickclk();
            if (i == 7) dataValid_a = 1'b0;
        end
        chk("t3_idle_valid", serialValid_a, 1'b0);
        chk("t3_idle_busy", busy_a, 1'b0);

        // Test 4: backpressure and tick stalls on word C3
        w4          = 8'hC3;
        rx4         = '0;
        dataIn_a    = w4;
        dataValid_a = 1'b1;
        tickclk();
        dataValid_a = 1'b0;
        dataIn_a    = 8'h00;
        n           = 0;
        prev_xfer   = 1'b1;
        prev_out    = 1'b0;
        prev_last   = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            serialReady_a = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            tick          = !((cyc >= 5) && (cyc <= 7));
            #1;
            chk("t4_valid", serialValid_a, 1'b1);
            if (!prev_xfer) begin
                chk("t4_hold_out", serialOut_a, prev_out);
                chk("t4_hold_last", serialLast_a, prev_last);
            end
            xfer_now = serialReady_a && tick;
            if (xfer_now) begin
                chk("t4_out", serialOut_a, w4[n]);
                chk("t4_last", serialLast_a, (n == 7));
                rx4[n] = serialOut_a;
                n++;
            end
            prev_xfer = xfer_now;
            prev_out  = serialOut_a;
            prev_last = serialLast_a;
            tickclk();
        end
        tick          = 1'b1;
        serialReady_a = 1'b1;
        chk_int("t4_count", n, 8);
        chk_int("t4_word", int'(rx4), int'(w4));
        chk("t4_idle_valid", serialValid_a, 1'b0);

        // Test 5: asynchronous reset mid-word after 3 bits
        dataIn_a    = 8'h5A;
        dataValid_a = 1'b1;
        tickclk();
        dataValid_a = 1'b0;
        tickclk();
        tickclk();
        tickclk();
        chk("t5_pre_valid", serialValid_a, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", serialValid_a, 1'b0);
        chk("t5_rst_busy", busy_a, 1'b0);
        chk("t5_rst_out", serialOut_a, 1'b0);
        chk("t5_rst_ready", dataReady_a, 1'b1);
        #2;
        reset = 1'b1;
        send_a(8'h3C, "t5");

        // Test 6: single-bit word, continuous stream
        dataIn_c    = 1'b1;
        dataValid_c = 1'b1;
        chk("t6_pre_ready", dataReady_c, 1'b1);
        tickclk();
        for (int i = 0; i < 5; i++) begin
            chk("t6_valid", serialValid_c, 1'b1);
            chk("t6_out", serialOut_c, 1'b1);
            chk("t6_last", serialLast_c, 1'b1);
            chk("t6_ready", dataReady_c, 1'b1);
            tickclk();
        end
        dataValid_c = 1'b0;
        chk("t6_final_valid", serialValid_c, 1'b1);
        tickclk();
        chk("t6_idle_valid", serialValid_c, 1'b0);
        chk("t6_idle_busy", busy_c, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_bus_serializer.md
Name: gate_bus_serializer

Overview:
- Transmit end of the bit-serial gate path: takes one NrOfBits-wide word, for example the result of a bus-wide gate, and shifts it out one bit per transfer.
- Parallel side uses a valid/ready handshake; serial side uses valid/ready with a last-bit marker.
- Same input/output bubble handling as the gate library, so a serial gate chain can be built from it.
- All state updates are qualified by the tick clock enable.

Parameters:
NrOfBits, 8, word width; legal range 1..64.
BubblesMask, 0, bit0=1 inverts dataIn at load; bit1=1 inverts serialOut while serialValid=1.
LsbFirst, 1, 1 = bit 0 transmitted first; 0 = bit NrOfBits-1 first.

Ports:
clock  input  1  single design clock, rising edge.
reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
tick  input  1  clock enable; no state changes when 0.
dataIn  input  NrOfBits  parallel word to transmit.
dataValid  input  1  dataIn is valid.
dataReady  output  1  block accepts dataIn this cycle.
serialOut  output  1  current serial bit.
serialValid  output  1  serialOut is valid.
serialReady  input  1  downstream accepts serialOut this cycle.
serialLast  output  1  current bit is the final bit of the word.
busy  output  1  a word is being shifted out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: serialValid=0, serialOut=0, serialLast=0, busy=0, dataReady=1.
  - Reset mid-word abandons the word with no partial completion, and outputs reach reset values without a clock edge.
  - After reset is released, operation resumes at the first rising edge with tick=1.
- States: IDLE, SHIFT.
- Accept: handshake on a rising edge where tick=1, dataValid=1 and dataReady=1.
  - Shift register loads dataIn, or ~dataIn if BubblesMask[0]=1.
  - Counter loads NrOfBits-1; state becomes SHIFT.
- Latency: first bit is valid in the cycle after the accept edge; there is no combinational path from dataIn to serialOut.
- SHIFT outputs:
  - serialValid=1, busy=1.
  - serialOut = current head bit (bit 0 if LsbFirst=1, else bit NrOfBits-1), XOR BubblesMask[1].
  - serialLast = (counter==0).
- Bit transfer: on an edge with tick=1, serialValid=1 and serialReady=1.
  - counter>0: shift register shifts one place toward the head, filling with 0; counter decrements.
  - counter==0: the word is done. If a new accept happens on the same edge, reload and stay in SHIFT; otherwise go to IDLE.
- Stall: serialReady=0 or tick=0 holds serialOut, serialValid and serialLast stable; no bit is lost or repeated.
- dataReady (combinational) = IDLE, or (SHIFT and counter==0 and serialReady=1 and tick=1).
  - This gives back-to-back words with no idle cycle.
- IDLE outputs: serialValid=0, serialOut=0 (not inverted by BubblesMask[1]), serialLast=0, busy=0.
- NrOfBits=1: every bit is both first and last; serialLast=1 for the whole SHIFT state, and back-to-back operation gives one word per transfer.
- dataIn is sampled only on the accept edge; changes at other times are ignored.
- dataValid may drop without being accepted; no protocol error is flagged.

Test Plan:
1. NrOfBits=8, LsbFirst=1, mask=0, dataIn=8'hA5 accepted, serialReady=1, tick=1 -> serialOut 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serialLast=1 on the 8th only; then IDLE, busy=0.
2. LsbFirst=0, BubblesMask=2'b11, dataIn=8'h0F -> input inverted to 8'hF0, output inverted again: serialOut 0,0,0,0,1,1,1,1.
3. Back-to-back: 8'h01 then 8'h80, dataValid held at 1 -> 16 consecutive valid bits with no gap; dataReady=1 only on the last bit of the first word; serialLast pulses at bits 8 and 16.
4. Backpressure: serialReady toggled 1,0,0,1,... and tick=0 for 3 cycles mid-word -> outputs held during stalls; received sequence equals the input word exactly, 8 transfers total.
5. Reset asserted asynchronously (between clock edges) mid-word after 3 bits -> serialValid=0, busy=0 immediately; after release, a new word 8'h3C is transmitted correctly from its first bit.
6. NrOfBits=1, dataIn=1'b1, continuous dataValid, serialReady=1 -> serialOut=1 and serialLast=1 every cycle after the first accept; dataReady stays 1.
